// File: rtl/fifo_read_packer_pkg.sv
// Shared types and sizing helpers for the FIFO read-side word packer.
package fifo_read_packer_pkg;

  localparam int MAX_RATIO = 16;

  typedef enum logic [1:0] {
    XFER_NONE,
    XFER_FULL,
    XFER_PART
  } xfer_e;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // A disabled timeout still needs a one-bit counter to keep the datapath legal.
  function automatic int idle_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic logic [MAX_RATIO-1:0] keep_mask(input int count);
    logic [MAX_RATIO-1:0] mask;
    for (int i = 0; i < MAX_RATIO; i++) begin
      mask[i] = (i < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_read_packer_if.sv
// FIFO read port plus wide valid/ready output bundle for the word packer.
interface fifo_read_packer_if #(
  parameter int BITS  = 8,
  parameter int RATIO = 4
);

  logic                  EMPTY;
  logic [BITS-1:0]       Q;
  logic                  RE;
  logic                  FLUSH;
  logic [BITS*RATIO-1:0] OUT_DATA;
  logic [RATIO-1:0]      OUT_KEEP;
  logic                  OUT_LAST;
  logic                  OUT_VALID;
  logic                  OUT_READY;

  modport master (
    input  EMPTY, Q, FLUSH, OUT_READY,
    output RE, OUT_DATA, OUT_KEEP, OUT_LAST, OUT_VALID
  );

  modport slave (
    output EMPTY, Q, FLUSH, OUT_READY,
    input  RE, OUT_DATA, OUT_KEEP, OUT_LAST, OUT_VALID
  );

endinterface

// File: rtl/fifo_read_packer_out_slot_reg.sv
// Single-entry valid/ready holding register for one packed output word.
module fifo_read_packer_out_slot_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic              last
);

  // The owner only loads when the slot is empty or draining, so a load always wins.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// Pops words from a fall-through FIFO and packs RATIO of them into one wide
// output word; partial words leave on FLUSH or after an idle timeout.
module fifo_read_packer
  import fifo_read_packer_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                CLOCK,
  input  logic                RESET,
  fifo_read_packer_if.master  bus
);

  localparam int DW = BITS * RATIO;
  localparam int CW = cnt_width(RATIO);
  localparam int IW = idle_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(RATIO);
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  logic [DW-1:0]    acc, acc_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [CW-1:0]    wr_lane;
  logic [IW-1:0]    idle, idle_next;
  logic             pend, pend_next;
  logic             slot_free;
  logic             pop;
  logic             timeout_hit;
  xfer_e            xfer;
  logic [RATIO-1:0] part_keep;
  logic [RATIO-1:0] load_keep;
  logic             load_last;

  assign slot_free = ~bus.OUT_VALID | bus.OUT_READY;

  always_comb begin
    xfer = XFER_NONE;
    if (slot_free) begin
      if (cnt == CNT_FULL) begin
        xfer = XFER_FULL;
      end else if (pend && cnt != '0) begin
        xfer = XFER_PART;
      end
    end
  end

  // A full accumulator may still pop if it drains on the same edge.
  assign pop    = RESET & ~bus.EMPTY & ~pend & ((cnt != CNT_FULL) | (xfer == XFER_FULL));
  assign bus.RE = pop;

  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    wr_lane  = cnt;
    if (xfer != XFER_NONE) begin
      acc_next = '0;
      cnt_next = '0;
      wr_lane  = '0;
    end
    if (pop) begin
      for (int i = 0; i < RATIO; i++) begin
        if (wr_lane == CW'(i)) begin
          acc_next[i*BITS +: BITS] = bus.Q;
        end
      end
      cnt_next = wr_lane + 1'b1;
    end

    // Pending is only raised when something will be left to emit.
    timeout_hit = (TIMEOUT > 0) && (idle == IDLE_LAST) && !pop;
    pend_next   = (xfer == XFER_NONE) ? pend : 1'b0;
    if ((bus.FLUSH || timeout_hit) && cnt_next != '0) begin
      pend_next = 1'b1;
    end

    idle_next = idle;
    if (pop || cnt == '0) begin
      idle_next = '0;
    end else if (idle != IDLE_MAX) begin
      idle_next = idle + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      acc  <= '0;
      cnt  <= '0;
      pend <= 1'b0;
      idle <= '0;
    end else begin
      acc  <= acc_next;
      cnt  <= cnt_next;
      pend <= pend_next;
      idle <= idle_next;
    end
  end

  always_comb begin
    part_keep = RATIO'(keep_mask(int'(cnt)));
    load_keep = (xfer == XFER_FULL) ? '1 : part_keep;
    load_last = (xfer == XFER_FULL) ? pend : 1'b1;
  end

  fifo_read_packer_out_slot_reg #(
    .DATA_W (DW),
    .KEEP_W (RATIO)
  ) u_out_slot (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .load      (xfer != XFER_NONE),
    .load_data (acc),
    .load_keep (load_keep),
    .load_last (load_last),
    .ready     (bus.OUT_READY),
    .valid     (bus.OUT_VALID),
    .data      (bus.OUT_DATA),
    .keep      (bus.OUT_KEEP),
    .last      (bus.OUT_LAST)
  );

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer with a queue-based FIFO model on the read port.
module tb_fifo_read_packer;

  localparam int BITS    = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;

  logic CLOCK = 1'b0;
  logic RESET;

  fifo_read_packer_if #(.BITS(BITS), .RATIO(RATIO)) bus ();

  fifo_read_packer #(
    .BITS    (BITS),
    .RATIO   (RATIO),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int          compare_count;
  int          mismatch_count;
  logic [7:0]  fifo_q[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        got_last[$];
  logic        re_hist[64];
  logic [7:0]  popped;
  int          re_sum;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + 8'(i));
    end
  endtask

  task automatic clearScenario();
    got_data.delete();
    got_keep.delete();
    got_last.delete();
    for (int i = 0; i < 64; i++) begin
      re_hist[i] = 1'b0;
    end
  endtask

  // One clock: drive the FIFO head, record RE and handshakes before the edge, pop after it.
  task automatic tick(input int t);
    bus.EMPTY = (fifo_q.size() == 0);
    bus.Q     = bus.EMPTY ? 8'h00 : fifo_q[0];
    #1;
    re_hist[t] = bus.RE;
    checkOutput("re_gated_by_empty", 64'(bus.RE & bus.EMPTY), 64'd0);
    if (bus.OUT_VALID && bus.OUT_READY) begin
      got_data.push_back(bus.OUT_DATA);
      got_keep.push_back(bus.OUT_KEEP);
      got_last.push_back(bus.OUT_LAST);
    end
    @(posedge CLOCK);
    if (re_hist[t]) begin
      popped = fifo_q.pop_front();
    end
    #1;
  endtask

  task automatic checkWord(input string tag, input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
    if (idx < got_data.size()) begin
      checkOutput({tag, "_data"}, 64'(got_data[idx]), 64'(d));
      checkOutput({tag, "_keep"}, 64'(got_keep[idx]), 64'(k));
      checkOutput({tag, "_last"}, 64'(got_last[idx]), 64'(l));
    end else begin
      checkOutput({tag, "_present"}, 64'(got_data.size()), 64'(idx + 1));
    end
  endtask

  function automatic int reCount(input int lo, input int hi);
    int s;
    s = 0;
    for (int i = lo; i <= hi; i++) begin
      s += int'(re_hist[i]);
    end
    return s;
  endfunction

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    RESET          = 1'b0;
    bus.EMPTY      = 1'b0;
    bus.Q          = 8'hAA;
    bus.FLUSH      = 1'b0;
    bus.OUT_READY  = 1'b1;

    #12;
    checkOutput("rst_valid", 64'(bus.OUT_VALID), 64'd0);
    checkOutput("rst_data",  64'(bus.OUT_DATA),  64'd0);
    checkOutput("rst_keep",  64'(bus.OUT_KEEP),  64'd0);
    checkOutput("rst_last",  64'(bus.OUT_LAST),  64'd0);
    checkOutput("rst_re",    64'(bus.RE),        64'd0);
    bus.EMPTY = 1'b1;
    RESET     = 1'b1;
    @(posedge CLOCK);
    #1;

    $display("[TB] streaming eight words");
    clearScenario();
    applyStimulus(8'h01, 8);
    for (int t = 1; t <= 12; t++) begin
      tick(t);
      if (t == 4) checkOutput("s1_latency_before", 64'(bus.OUT_VALID), 64'd0);
      if (t == 5) checkOutput("s1_latency_after",  64'(bus.OUT_VALID), 64'd1);
    end
    re_sum = reCount(1, 8);
    checkOutput("s1_re_run", 64'(re_sum), 64'd8);
    re_sum = reCount(1, 12);
    checkOutput("s1_re_total", 64'(re_sum), 64'd8);
    checkOutput("s1_words", 64'(got_data.size()), 64'd2);
    checkWord("s1_w0", 0, 32'h04030201, 4'hF, 1'b0);
    checkWord("s1_w1", 1, 32'h08070605, 4'hF, 1'b0);

    $display("[TB] backpressure");
    clearScenario();
    bus.OUT_READY = 1'b0;
    applyStimulus(8'h01, 8);
    for (int t = 1; t <= 13; t++) begin
      if (t == 11) bus.OUT_READY = 1'b1;
      tick(t);
      if (t == 6)  checkOutput("s2_hold_early", 64'(bus.OUT_DATA), 64'h04030201);
      if (t == 10) begin
        checkOutput("s2_hold_late",  64'(bus.OUT_DATA),  64'h04030201);
        checkOutput("s2_hold_valid", 64'(bus.OUT_VALID), 64'd1);
      end
    end
    checkOutput("s2_re_word8",  64'(re_hist[8]),  64'd1);
    checkOutput("s2_re_stall9", 64'(re_hist[9]),  64'd0);
    checkOutput("s2_re_stall10", 64'(re_hist[10]), 64'd0);
    re_sum = reCount(1, 13);
    checkOutput("s2_re_total", 64'(re_sum), 64'd8);
    checkOutput("s2_words", 64'(got_data.size()), 64'd2);
    checkWord("s2_w0", 0, 32'h04030201, 4'hF, 1'b0);
    checkWord("s2_w1", 1, 32'h08070605, 4'hF, 1'b0);

    $display("[TB] explicit flush");
    clearScenario();
    applyStimulus(8'h01, 3);
    for (int t = 1; t <= 10; t++) begin
      bus.FLUSH = (t == 4) || (t == 7);
      tick(t);
      if (t == 5) begin
        checkOutput("s3_part_valid", 64'(bus.OUT_VALID), 64'd1);
        checkOutput("s3_part_data",  64'(bus.OUT_DATA),  64'h00030201);
        checkOutput("s3_part_keep",  64'(bus.OUT_KEEP),  64'h7);
        checkOutput("s3_part_last",  64'(bus.OUT_LAST),  64'd1);
      end
      if (t == 9) checkOutput("s3_empty_flush", 64'(bus.OUT_VALID), 64'd0);
    end
    bus.FLUSH = 1'b0;
    checkOutput("s3_words", 64'(got_data.size()), 64'd1);

    $display("[TB] idle timeout");
    clearScenario();
    applyStimulus(8'h11, 2);
    for (int t = 1; t <= 21; t++) begin
      tick(t);
      if (t == 18) checkOutput("s4_before_timeout", 64'(bus.OUT_VALID), 64'd0);
      if (t == 19) checkOutput("s4_at_timeout",     64'(bus.OUT_VALID), 64'd1);
    end
    checkOutput("s4_words", 64'(got_data.size()), 64'd1);
    checkWord("s4_w0", 0, 32'h00001211, 4'h3, 1'b1);

    clearScenario();
    applyStimulus(8'h21, 1);
    for (int t = 1; t <= 31; t++) begin
      if (t == 12) applyStimulus(8'h22, 1);
      tick(t);
      if (t == 18) checkOutput("s4b_no_early",  64'(bus.OUT_VALID), 64'd0);
      if (t == 28) checkOutput("s4b_restarted", 64'(bus.OUT_VALID), 64'd0);
      if (t == 29) checkOutput("s4b_timeout",   64'(bus.OUT_VALID), 64'd1);
    end
    checkOutput("s4b_words", 64'(got_data.size()), 64'd1);
    checkWord("s4b_w0", 0, 32'h00002221, 4'h3, 1'b1);

    $display("[TB] flush with the last pop");
    clearScenario();
    applyStimulus(8'h31, 5);
    for (int t = 1; t <= 8; t++) begin
      bus.FLUSH = (t == 4);
      tick(t);
    end
    bus.FLUSH = 1'b0;
    checkOutput("s5_re_fill",     64'(re_hist[4]), 64'd1);
    checkOutput("s5_re_transfer", 64'(re_hist[5]), 64'd0);
    checkOutput("s5_re_resume",   64'(re_hist[6]), 64'd1);
    checkWord("s5_w0", 0, 32'h34333231, 4'hF, 1'b1);

    $display("[TB] reset during accumulation");
    clearScenario();
    bus.OUT_READY = 1'b0;
    applyStimulus(8'h41, 6);
    for (int t = 1; t <= 5; t++) begin
      tick(t);
    end
    checkOutput("s6_pre_valid", 64'(bus.OUT_VALID), 64'd1);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("s6_rst_valid", 64'(bus.OUT_VALID), 64'd0);
    checkOutput("s6_rst_data",  64'(bus.OUT_DATA),  64'd0);
    checkOutput("s6_rst_keep",  64'(bus.OUT_KEEP),  64'd0);
    checkOutput("s6_rst_last",  64'(bus.OUT_LAST),  64'd0);
    checkOutput("s6_rst_re",    64'(bus.RE),        64'd0);
    @(posedge CLOCK);
    #1;
    bus.EMPTY = 1'b1;
    #2;
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    fifo_q.delete();
    clearScenario();
    bus.OUT_READY = 1'b1;
    applyStimulus(8'h51, 4);
    for (int t = 1; t <= 7; t++) begin
      tick(t);
    end
    checkOutput("s6_words", 64'(got_data.size()), 64'd1);
    checkWord("s6_w0", 0, 32'h54535251, 4'hF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/fifo_read_packer.md
# fifo_read_packer

Read-side consumer for the asynchronous FIFO in the read clock domain. It pops BITS-wide words from the FIFO's first-word-fall-through read port and packs RATIO consecutive words into one wide output word with a valid/ready handshake. Partial words are emitted on an explicit flush or after an idle timeout. It sits between the FIFO read port and any wide datapath consumer.

## Interface
- BITS, 8: FIFO word width.
- RATIO, 4: words per output word; 2..16.
- TIMEOUT, 16: idle cycles with a partial word before auto-flush; 0 disables auto-flush.
- CLOCK  in  1  read-domain clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- EMPTY  in  1  FIFO empty flag, registered in FIFO; Q valid when 0.
- Q  in  BITS  FIFO head word (fall-through).
- RE  out  1  FIFO pop; a word is consumed at the edge where RE=1.
- FLUSH  in  1  request emission of the current partial word.
- OUT_DATA  out  BITS*RATIO  packed word; lane i = bits [i*BITS +: BITS], lane 0 = oldest.
- OUT_KEEP  out  RATIO  lane-valid mask, contiguous from lane 0.
- OUT_LAST  out  1  word was emitted by flush or timeout.
- OUT_VALID  out  1  output word present.
- OUT_READY  in  1  consumer accepts when OUT_VALID & OUT_READY.

## Operation
- State: accumulator ACC (BITS*RATIO), count CNT (0..RATIO), sticky PEND (flush pending), idle counter IDLE, output slot (OUT_*).
- slot_free = ~OUT_VALID | OUT_READY.
- xfer_full = (CNT==RATIO) & slot_free.
- xfer_part = PEND & (CNT>0) & (CNT<RATIO) & slot_free.
- RE = RESET & ~EMPTY & ~PEND & ((CNT<RATIO) | xfer_full). RE is combinational, and is never asserted while EMPTY=1 or during reset.
- Pop without transfer: Q written into lane CNT, CNT+1.
- xfer_full: slot loads ACC, KEEP all ones, LAST = PEND. If a pop occurs on the same edge, Q goes into lane 0 and CNT=1; otherwise CNT=0 and ACC cleared. PEND cleared.
- xfer_part: slot loads ACC, KEEP = (1<<CNT)-1, LAST=1, CNT=0, ACC=0, PEND=0. No pop on this edge.
- FLUSH sampled at edge: PEND set if CNT after that edge is >0, including a word popped on the same edge. FLUSH with CNT=0 and no pop is ignored, so no empty words are ever emitted.
- Timeout: IDLE resets on any pop or when CNT==0, and increments otherwise. When IDLE reaches TIMEOUT-1 with CNT>0, PEND is set. IDLE saturates.
- While PEND=1, popping stops until the partial word is transferred.
- Slot: held stable (DATA/KEEP/LAST) while OUT_VALID & ~OUT_READY. OUT_VALID clears on handshake unless reloaded on the same edge.
- Reset (asynchronous, any time): all state cleared. Partial data and any undelivered slot word are discarded.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_KEEP=0, OUT_LAST=0, RE=0; CNT=0, PEND=0, IDLE=0.
- Latency: the RATIO-th word popped at edge k gives OUT_VALID=1 after edge k+1 if the slot is free.
- Throughput: one output word per RATIO cycles with EMPTY=0 and OUT_READY=1; no bubbles.
- Backpressure: with the slot held and CNT==RATIO, RE=0 until OUT_READY.
- FLUSH at edge k with CNT>0 gives the partial word in the slot after edge k+1 if the slot is free.

## Structure
- Shared package: CNT width function clog2(RATIO+1), IDLE width function clog2(TIMEOUT+1), and the KEEP-mask function from a count.
- Sub-module out_slot_reg: a single-entry valid/ready holding register (DATA, KEEP, LAST) with a load input, instantiated once.
- Top level holds ACC, CNT, PEND, IDLE and the RE logic.

## Test plan
- Reset, then 8 words 0x01..0x08 with EMPTY=0 and OUT_READY=1 (BITS=8, RATIO=4) -> OUT_DATA 0x04030201 then 0x08070605, KEEP=0xF, LAST=0, RE high for 8 consecutive cycles.
- Same stimulus with OUT_READY=0 for 10 cycles -> first word held stable; RE drops after word 8 enters ACC; no data lost after OUT_READY rises.
- 3 words, then FLUSH -> OUT_DATA 0x00030201, KEEP=0x7, LAST=1; FLUSH with CNT=0 -> no OUT_VALID.
- 2 words, then EMPTY=1 for TIMEOUT cycles -> partial word, KEEP=0x3, LAST=1; a word arriving before timeout resets IDLE.
- FLUSH on the same edge as the 4th pop -> full word with KEEP=0xF, LAST=1, and no pop on the transfer edge.
- RESET asserted mid-accumulation with OUT_VALID=1 -> all outputs 0 immediately; the next word after release lands in lane 0.
